// File: rtl/memory_access_stage.sv
// MEM stage: byte/half/word loads and stores into the data RAM, MEM/WB latch and forwarding tap.
// Optional MEM_DEBUG_PORT_EN adds a second synchronous read port for memory dumps.
module memory_access_stage #(
  parameter int NB_BITS = 32,
  parameter int NB_ADDR = 10,
  parameter int NB_REG  = 5,
  parameter int NB_MEM  = 5,
  parameter int NB_WB   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_debug_enb,
  input  logic [NB_BITS-1:0] i_alu_out,
  input  logic [NB_BITS-1:0] i_data_reg,
  input  logic [NB_REG-1:0]  i_reg_dst,
  input  logic [NB_MEM-1:0]  i_mem_ctl,
  input  logic [NB_WB-1:0]   i_wb_ctl,
  output logic [NB_BITS-1:0] o_wb_data,
  output logic [NB_REG-1:0]  o_reg_dst,
  output logic [NB_WB-1:0]   o_wb_ctl,
  output logic [NB_BITS-1:0] o_mem_wb_reg_hz,
  output logic               o_misaligned
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_BITS-1:0] o_dbg_data
`endif
);

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  logic [NB_BITS-1:0] ram [2**NB_ADDR];

  logic               rd, wr, uns, mis;
  logic [1:0]         size, off;
  logic [NB_ADDR-1:0] widx;
  logic [3:0]         be;
  logic [NB_BITS-1:0] wdata;
  logic               unused_alu_hi;

  assign rd   = i_mem_ctl[0];
  assign wr   = i_mem_ctl[1];
  assign size = i_mem_ctl[3:2];
  assign uns  = i_mem_ctl[4];
  assign off  = i_alu_out[1:0];
  assign widx = i_alu_out[NB_ADDR+1:2];
  assign unused_alu_hi = ^i_alu_out[NB_BITS-1:NB_ADDR+2];

  // size 11 is reserved and behaves as a word access
  assign mis = (rd | wr) && ((size == SZ_H && off[0]) || (size[1] && off != 2'b00));

  // Store data is replicated across lanes so the byte-enables alone pick the target bytes.
  always_comb begin
    be    = 4'b1111;
    wdata = i_data_reg;
    case (size)
      SZ_B: begin
        be    = 4'b0001 << off;
        wdata = {4{i_data_reg[7:0]}};
      end
      SZ_H: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_data_reg[15:0]}};
      end
      default: ;
    endcase
    if (!(wr && !mis && i_debug_enb && i_rst)) be = 4'b0000;
  end

  always_ff @(posedge i_clk) begin
    for (int l = 0; l < 4; l++)
      if (be[l]) ram[widx][8*l +: 8] <= wdata[8*l +: 8];
  end

  // MEM/WB latch; the RAM word is captured here, lane select happens downstream.
  logic [NB_BITS-1:0] alu_q, alu_d, rdata_q, rdata_d;
  logic [NB_REG-1:0]  reg_dst_q, reg_dst_d;
  logic [NB_WB-1:0]   wb_ctl_q, wb_ctl_d;
  logic [1:0]         off_q, off_d, size_q, size_d;
  logic               uns_q, uns_d, mis_q, mis_d;

  always_comb begin
    alu_d     = alu_q;
    rdata_d   = rdata_q;
    reg_dst_d = reg_dst_q;
    wb_ctl_d  = wb_ctl_q;
    off_d     = off_q;
    size_d    = size_q;
    uns_d     = uns_q;
    mis_d     = mis_q;
    if (i_debug_enb) begin
      alu_d       = i_alu_out;
      rdata_d     = ram[widx];
      reg_dst_d   = i_reg_dst;
      wb_ctl_d    = i_wb_ctl;
      wb_ctl_d[0] = i_wb_ctl[0] & ~mis;
      off_d       = off;
      size_d      = size;
      uns_d       = uns;
      mis_d       = mis;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      alu_q     <= '0;
      rdata_q   <= '0;
      reg_dst_q <= '0;
      wb_ctl_q  <= '0;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      alu_q     <= alu_d;
      rdata_q   <= rdata_d;
      reg_dst_q <= reg_dst_d;
      wb_ctl_q  <= wb_ctl_d;
      off_q     <= off_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      mis_q     <= mis_d;
    end
  end

  logic [7:0]         lane8;
  logic [15:0]        lane16;
  logic [NB_BITS-1:0] load_data;

  always_comb begin
    lane8  = rdata_q[8*off_q +: 8];
    lane16 = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (size_q)
      SZ_B:    load_data = {{(NB_BITS-8){lane8[7] & ~uns_q}}, lane8};
      SZ_H:    load_data = {{(NB_BITS-16){lane16[15] & ~uns_q}}, lane16};
      default: load_data = rdata_q;
    endcase
    if (mis_q) load_data = '0;
  end

  assign o_wb_data       = wb_ctl_q[1] ? load_data : alu_q;
  assign o_mem_wb_reg_hz = o_wb_data;
  assign o_reg_dst       = reg_dst_q;
  assign o_wb_ctl        = wb_ctl_q;
  assign o_misaligned    = mis_q;

`ifdef MEM_DEBUG_PORT_EN
  logic [NB_BITS-1:0] dbg_data_q, dbg_data_d;

  assign dbg_data_d = ram[i_dbg_addr];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) dbg_data_q <= '0;
    else        dbg_data_q <= dbg_data_d;
  end

  assign o_dbg_data = dbg_data_q;
`endif

endmodule
